// File: rtl/control_channel_arbiter.sv
// rtl/control_channel_arbiter.sv - round-robin grant scheduler for the shared control/data channel
//
// Collects transmit requests from every node's control_tx_packet, grants the
// shared channel round-robin, broadcasts the grant as {node_id, GRANT_CODE}
// and forwards the granted node's data word for the length of its slot.
//
// Ports
//   clk               in   1             single clock, rising edge
//   rst               in   1             synchronous, active-high reset
//   max_node          in   16            active node count; ids above it are never granted
//   node_control_tx   in   32*NUM_NODES  port i = control_tx_packet of node i+1
//   node_data_tx      in   32*NUM_NODES  port i = data_tx_packet of node i+1
//   control_rx_packet out  32            grant broadcast, 0 when no grant
//   data_rx_node_id   out  16            id owning the data channel, 0 when idle
//   data_rx_packet    out  32            forwarded data word, 0 when idle
//   busy              out  1             high in GRANT, SLOT and GAP

module control_channel_arbiter #(
  parameter int          NUM_NODES   = 4,
  parameter int          SLOT_CYCLES = 8,
  parameter int          GAP_CYCLES  = 1,
  parameter logic [15:0] GRANT_CODE  = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            max_node,
  input  logic [32*NUM_NODES-1:0] node_control_tx,
  input  logic [32*NUM_NODES-1:0] node_data_tx,
  output logic [31:0]            control_rx_packet,
  output logic [15:0]            data_rx_node_id,
  output logic [31:0]            data_rx_packet,
  output logic                   busy
);

  localparam int PW      = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int CNT_MAX = (SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SLOT  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [PW-1:0]        rr, rr_n;
  logic [PW-1:0]        win, win_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [NUM_NODES-1:0] pending, pending_n;
  logic [NUM_NODES-1:0] req_valid;
  logic [NUM_NODES-1:0] mask;
  logic                 found;
  logic [PW-1:0]        pick;
  logic [PW-1:0]        idx;
  logic [31:0]          sel_data;
  logic [31:0]          ctrl_n;
  logic [15:0]          id_n;
  logic [31:0]          data_n;

  // Port index k steps after base, wrapping at NUM_NODES (k in 1..NUM_NODES).
  function automatic logic [PW-1:0] port_after(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_NODES) s = s - NUM_NODES;
    return PW'(s);
  endfunction

  // A request is only valid when the source field names the port's own node
  // and the payload is non-zero. Ports at or above max_node are masked.
  always_comb begin
    req_valid = '0;
    mask      = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      req_valid[i] = (node_control_tx[32*i+16 +: 16] == 16'(i + 1)) &&
                     (node_control_tx[32*i +: 16] != 16'h0000);
      mask[i]      = (32'(i) < {16'h0000, max_node});
    end
  end

  // Scanning every port from rr+1 around to rr with masked ports skipped gives
  // the same order as wrapping at the effective node count.
  always_comb begin
    found = 1'b0;
    pick  = rr;
    idx   = rr;
    for (int k = 1; k <= NUM_NODES; k++) begin
      idx = port_after(rr, k);
      if (!found && pending[idx] && mask[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_n   = state;
    win_n     = win;
    rr_n      = rr;
    cnt_n     = cnt;
    pending_n = pending | req_valid;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          win_n   = pick;
          rr_n    = pick;
        end
      end
      GRANT: begin
        // Clearing after the OR makes the grant win over a same-cycle request.
        pending_n[win] = 1'b0;
        cnt_n          = '0;
        state_n        = SLOT;
      end
      SLOT: begin
        if (cnt == CW'(SLOT_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    sel_data = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      if (win_n == PW'(i)) sel_data = node_data_tx[32*i +: 32];
    end

    // Outputs are registered from the next state so they line up with it.
    ctrl_n = (state_n == GRANT) ? {16'(win_n) + 16'd1, GRANT_CODE} : 32'h0;
    id_n   = (state_n == SLOT) ? 16'(win_n) + 16'd1 : 16'h0;
    data_n = (state_n == SLOT) ? sel_data : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      rr                <= PW'(NUM_NODES - 1);
      win               <= '0;
      cnt               <= '0;
      pending           <= '0;
      control_rx_packet <= '0;
      data_rx_node_id   <= '0;
      data_rx_packet    <= '0;
      busy              <= 1'b0;
    end else begin
      state             <= state_n;
      rr                <= rr_n;
      win               <= win_n;
      cnt               <= cnt_n;
      pending           <= pending_n;
      control_rx_packet <= ctrl_n;
      data_rx_node_id   <= id_n;
      data_rx_packet    <= data_n;
      busy              <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_control_channel_arbiter.sv
// tb/tb_control_channel_arbiter.sv - self-checking bench for control_channel_arbiter
module tb_control_channel_arbiter;

  localparam int N = 4;
  localparam int S = 8;
  localparam int G = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [15:0]     max_node = 16'd4;
  logic [32*N-1:0] ctl = '0;
  logic [32*N-1:0] dat = '0;
  logic [31:0]     crx;
  logic [15:0]     did;
  logic [31:0]     drx;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: pending flags, round-robin pointer, and the offset in
  // cycles from the grant cycle (0 = grant, 1..S = slot, S+1..S+G = gap).
  bit          m_pend[N];
  int          m_rr = N - 1;
  bit          m_idle = 1'b1;
  int          m_o = 0;
  int          m_w = 0;
  logic [31:0] e_ctrl = '0;
  logic [15:0] e_id = '0;
  logic [31:0] e_data = '0;
  logic        e_busy = 1'b0;

  int          glog_cyc[$];
  logic [31:0] glog_val[$];

  control_channel_arbiter #(
    .NUM_NODES(N), .SLOT_CYCLES(S), .GAP_CYCLES(G), .GRANT_CODE(16'hFFFF)
  ) dut (
    .clk(clk), .rst(rst), .max_node(max_node),
    .node_control_tx(ctl), .node_data_tx(dat),
    .control_rx_packet(crx), .data_rx_node_id(did),
    .data_rx_packet(drx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit old[N];
    bit clr;
    bit hit;
    int e;
    old = m_pend;
    clr = !m_idle && (m_o == 0);
    if (rst) begin
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_rr = N - 1;
      m_idle = 1'b1;
      m_o = 0;
    end else begin
      e = (int'(max_node) < N) ? int'(max_node) : N;
      if (m_idle) begin
        hit = 1'b0;
        for (int p = m_rr + 1; p < e; p++)
          if (!hit && old[p]) begin hit = 1'b1; m_w = p; end
        for (int p = 0; p <= m_rr && p < e; p++)
          if (!hit && old[p]) begin hit = 1'b1; m_w = p; end
        if (hit) begin m_idle = 1'b0; m_o = 0; m_rr = m_w; end
      end else begin
        m_o++;
        if (m_o == 1 + S + G) m_idle = 1'b1;
      end
      for (int i = 0; i < N; i++)
        if (ctl[32*i+16 +: 16] == 16'(i + 1) && ctl[32*i +: 16] != 16'h0) m_pend[i] = 1'b1;
      if (clr) m_pend[m_w] = 1'b0;
    end
    e_busy = !m_idle;
    e_ctrl = (!m_idle && m_o == 0) ? {16'(m_w + 1), 16'hFFFF} : 32'h0;
    if (!m_idle && m_o >= 1 && m_o <= S) begin
      e_id = 16'(m_w + 1);
      e_data = dat[32*m_w +: 32];
    end else begin
      e_id = 16'h0;
      e_data = 32'h0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("ctrl", crx, e_ctrl);
    chk("node_id", {16'h0, did}, {16'h0, e_id});
    chk("data", drx, e_data);
    chk("busy", {31'h0, busy}, {31'h0, e_busy});
    if (crx !== 32'h0) begin
      glog_cyc.push_back(cyc);
      glog_val.push_back(crx);
    end
    for (int i = 0; i < N; i++) dat[32*i +: 32] = $urandom;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_log();
    glog_cyc.delete();
    glog_val.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ctl = '0;
    max_node = 16'd4;
    tick();
    tick();
    rst = 1'b0;
    clear_log();
  endtask

  initial begin
    int c0;
    int cnt;

    // Reset state
    do_reset();
    chk("rst_ctrl", crx, 32'h0);
    chk("rst_id", {16'h0, did}, 32'h0);
    chk("rst_data", drx, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);

    // T1 single request from node 1
    ctl[31:0] = 32'h00010003;
    tick();
    c0 = cyc;
    ctl = '0;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (did == 16'd1) cnt++;
    end
    chk("t1_grants", 32'(glog_val.size()), 32'd1);
    chk("t1_grant", glog_val[0], 32'h0001FFFF);
    chk("t1_latency", 32'(glog_cyc[0]), 32'(c0 + 1));
    chk("t1_slot_len", 32'(cnt), 32'd8);

    // T2 all four request together
    do_reset();
    for (int i = 0; i < N; i++) ctl[32*i +: 32] = {16'(i + 1), 16'h0001};
    tick();
    ctl = '0;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (busy) cnt++;
    end
    chk("t2_grants", 32'(glog_val.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_order", glog_val[k], {16'(k + 1), 16'hFFFF});
      if (k > 0) chk("t2_spacing", 32'(glog_cyc[k] - glog_cyc[k-1]), 32'd11);
    end
    chk("t2_busy_cycles", 32'(cnt), 32'd40);
    chk("t2_busy_end", {31'h0, busy}, 32'h0);

    // T3 fairness after node 2 is served
    do_reset();
    ctl[63:32] = 32'h00020005;
    tick();
    ctl = '0;
    run(12);
    ctl[31:0] = 32'h00010001;
    ctl[95:64] = 32'h00030001;
    tick();
    ctl = '0;
    run(30);
    chk("t3_grants", 32'(glog_val.size()), 32'd3);
    chk("t3_first", glog_val[0], 32'h0002FFFF);
    chk("t3_second", glog_val[1], 32'h0003FFFF);
    chk("t3_third", glog_val[2], 32'h0001FFFF);

    // T4 masking by max_node, pending kept until unmasked
    do_reset();
    max_node = 16'd2;
    ctl[95:64] = 32'h00030001;
    tick();
    ctl = '0;
    run(20);
    chk("t4_masked", 32'(glog_val.size()), 32'd0);
    max_node = 16'd4;
    run(15);
    chk("t4_unmasked", 32'(glog_val.size()), 32'd1);
    chk("t4_grant", glog_val[0], 32'h0003FFFF);

    // T5 malformed requests
    do_reset();
    ctl[63:32] = 32'h00030001;
    tick();
    ctl[63:32] = 32'h00020000;
    tick();
    ctl = '0;
    run(15);
    chk("t5_no_grant", 32'(glog_val.size()), 32'd0);

    // T6 reset during slot cycle 3
    do_reset();
    ctl[31:0] = 32'h00010001;
    tick();
    ctl = '0;
    tick();
    ctl[63:32] = 32'h00020001;
    tick();
    ctl = '0;
    tick();
    tick();
    chk("t6_in_slot", {16'h0, did}, 32'd1);
    rst = 1'b1;
    tick();
    chk("t6_ctrl", crx, 32'h0);
    chk("t6_id", {16'h0, did}, 32'h0);
    chk("t6_data", drx, 32'h0);
    chk("t6_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    clear_log();
    run(20);
    chk("t6_no_grant", 32'(glog_val.size()), 32'd0);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 900; n++) begin
      for (int i = 0; i < N; i++) begin
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 3) ctl[32*i +: 32] = {16'(i + 1), 16'($urandom) | 16'h0001};
        else if (r == 3) ctl[32*i +: 32] = $urandom;
        else ctl[32*i +: 32] = 32'h0;
      end
      if (n % 50 == 0) max_node = 16'($urandom_range(0, 5));
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    ctl = '0;
    run(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
